// File: rtl/conv_mac_arbiter_if.sv
// Bundle between the conv engines and the shared MAC, plus the result port.
// Handshake: a word moves on a rising clk edge where valid and ready are both
// high. A source holds valid and its payload stable until that edge, and does
// not wait for ready before raising valid. A sink may raise or drop ready freely.
interface conv_mac_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 16
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_f;
    logic [NREQ-1:0]   req_last;
    logic              y_valid;
    logic              y_ready;
    logic [W-1:0]      y_data;
    logic [IDW-1:0]    y_id;

    // Requester / result-consumer side.
    modport master (
        output req_valid, req_x, req_f, req_last, y_ready,
        input  req_ready, y_valid, y_data, y_id
    );

    // Shared MAC side.
    modport slave (
        input  req_valid, req_x, req_f, req_last, y_ready,
        output req_ready, y_valid, y_data, y_id
    );
endinterface

// File: rtl/conv_mac_arbiter.sv
// Round-robin arbiter that lends one saturating MAC (mult, saturate, pipe
// register, saturating accumulate, ReLU) to one requester for a whole job.
module conv_mac_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    conv_mac_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, OUT} state_t;

    state_t          state_q;
    logic [IDW-1:0]  gnt_q;
    logic [IDW-1:0]  ptr_q;
    logic [NREQ-1:0] req_ready_q;
    logic            y_valid_q;
    logic [W-1:0]    y_data_q;
    logic [IDW-1:0]  y_id_q;
    logic            busy_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    pipe_q;
    logic            pipe_v_q;

    logic [W-1:0]    x_sel;
    logic [W-1:0]    f_sel;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    prod_sat;
    logic [W:0]      sum;
    logic [W-1:0]    sum_sat;
    logic [W-1:0]    acc_d;
    logic [W-1:0]    relu_d;
    logic            accept;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_d;
    int              idx;

    assign bus.req_ready = req_ready_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.y_data    = y_data_q;
    assign bus.y_id      = y_id_q;
    assign busy          = busy_q;

    assign accept = (state_q == BUSY) && bus.req_valid[gnt_q] && req_ready_q[gnt_q];

    // Datapath: signed product and sum, each clamped to the W-bit signed range.
    always_comb begin
        x_sel = bus.req_x[int'(gnt_q)*W +: W];
        f_sel = bus.req_f[int'(gnt_q)*W +: W];
        prod  = {{W{x_sel[W-1]}}, x_sel} * {{W{f_sel[W-1]}}, f_sel};
        // The product fits when its top W+1 bits are all copies of the sign.
        if (prod[2*W-1:W-1] == {(W+1){prod[2*W-1]}}) prod_sat = prod[W-1:0];
        else prod_sat = prod[2*W-1] ? SMIN : SMAX;
        sum = {acc_q[W-1], acc_q} + {pipe_q[W-1], pipe_q};
        if (sum[W] == sum[W-1]) sum_sat = sum[W-1:0];
        else sum_sat = sum[W] ? SMIN : SMAX;
        acc_d  = pipe_v_q ? sum_sat : acc_q;
        relu_d = acc_d[W-1] ? '0 : acc_d;
    end

    // Round-robin pick: first valid requester after the last one granted.
    always_comb begin
        gnt_found = 1'b0;
        gnt_d     = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_d     = IDW'(idx);
            end
        end
    end

    // Job FSM with registered handshake outputs and the accumulate pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            req_ready_q <= '0;
            y_valid_q   <= 1'b0;
            y_data_q    <= '0;
            y_id_q      <= '0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            pipe_q      <= '0;
            pipe_v_q    <= 1'b0;
        end else begin
            if (pipe_v_q) acc_q <= sum_sat;
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q       <= gnt_d;
                        ptr_q       <= gnt_d;
                        req_ready_q <= NREQ'(1) << gnt_d;
                        busy_q      <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        pipe_q   <= prod_sat;
                        pipe_v_q <= 1'b1;
                        if (bus.req_last[gnt_q]) begin
                            req_ready_q <= '0;
                            state_q     <= DRAIN;
                        end
                    end else begin
                        pipe_v_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The final product is folded in this cycle; publish the sum now.
                    pipe_v_q  <= 1'b0;
                    y_valid_q <= 1'b1;
                    y_data_q  <= relu_d;
                    y_id_q    <= gnt_q;
                    state_q   <= OUT;
                end
                OUT: begin
                    if (bus.y_ready) begin
                        y_valid_q <= 1'b0;
                        acc_q     <= '0;
                        pipe_v_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_arbiter.sv
// Directed bench for conv_mac_arbiter: queued requester drivers, a result
// scoreboard fed by a dot-product model, and per-cycle protocol checks.
module tb_conv_mac_arbiter;
    localparam int NREQ = 2;
    localparam int W    = 16;
    localparam int IDW  = $clog2(NREQ);

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] f;
        logic         last;
        int           gap;
    } pair_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    conv_mac_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    conv_mac_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    pair_t            pq [NREQ][$];
    logic [IDW+W-1:0] exp_q [$];
    int               hs_q [$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               last_acc_cyc = 0;
    logic [NREQ-1:0]  acc_now;
    logic             hold;
    logic             prev_v;
    logic [W-1:0]     hold_data;
    logic [IDW-1:0]   hold_id;
    logic [IDW+W-1:0] e;
    int               expv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Dot product with each product and each running sum clamped to W-bit signed.
    function automatic int mac_model(input int n, input int xs[3], input int fs[3]);
        longint hi, lo, acc, p;
        hi  = (longint'(1) << (W - 1)) - 1;
        lo  = -hi - 1;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            p = longint'(xs[i]) * longint'(fs[i]);
            if (p > hi) p = hi;
            if (p < lo) p = lo;
            acc = acc + p;
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        return (acc < 0) ? 0 : int'(acc);
    endfunction

    // Queue a job for requester r; gap = idle cycles before each pair after the first.
    task automatic submit(input int r, input int n, input int x0, input int x1, input int x2,
                          input int f0, input int f1, input int f2, input int gap,
                          input bit want, output int ev);
        int    xs[3];
        int    fs[3];
        pair_t p;
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        fs[0] = f0; fs[1] = f1; fs[2] = f2;
        ev = mac_model(n, xs, fs);
        for (int i = 0; i < n; i++) begin
            p.x    = W'(xs[i]);
            p.f    = W'(fs[i]);
            p.last = (i == n - 1);
            p.gap  = (i == 0) ? 0 : gap;
            pq[r].push_back(p);
        end
        if (want) exp_q.push_back({IDW'(r), W'(ev)});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((pq[0].size() != 0 || pq[1].size() != 0 || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_done: got timeout expected all results", name);
            pq[0].delete();
            pq[1].delete();
            exp_q.delete();
        end
        tick();
    endtask

    // Requester drivers: present queue heads, retire a pair once it is accepted.
    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_f     = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                acc_now[i] = !reset && bus.req_valid[i] && bus.req_ready[i];
                if (acc_now[i] && bus.req_last[i]) last_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                pair_t p;
                if (acc_now[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() > 0) begin
                    p = pq[i][0];
                    if (p.gap > 0) begin
                        p.gap    = p.gap - 1;
                        pq[i][0] = p;
                        bus.req_valid[i] = 1'b0;
                        bus.req_last[i]  = 1'b0;
                    end else begin
                        bus.req_valid[i]     = 1'b1;
                        bus.req_x[i*W +: W]  = p.x;
                        bus.req_f[i*W +: W]  = p.f;
                        bus.req_last[i]      = p.last;
                    end
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Per-cycle checks: grant exclusivity, result hold, latency, scoreboard.
    initial begin
        hold   = 1'b0;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold   = 1'b0;
                prev_v = 1'b0;
            end else begin
                chk("ready_onehot0", longint'($countones(bus.req_ready) <= 1), 1);
                if (hold) begin
                    chk("hold_valid", bus.y_valid, 1);
                    chk("hold_data", bus.y_data, hold_data);
                    chk("hold_id", bus.y_id, hold_id);
                end
                if (bus.y_valid) begin
                    chk("ready_while_out", bus.req_ready, 0);
                    chk("busy_while_out", busy, 1);
                    if (!prev_v) chk("latency", cyc - last_acc_cyc, 2);
                end
                if (bus.y_valid && bus.y_ready) begin
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got id %0d data %0d expected none",
                                 bus.y_id, bus.y_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("y_data", bus.y_data, e[W-1:0]);
                        chk("y_id", bus.y_id, e[IDW+W-1:W]);
                    end
                end
                hold      = bus.y_valid && !bus.y_ready;
                hold_data = bus.y_data;
                hold_id   = bus.y_id;
                prev_v    = bus.y_valid;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.y_ready = 1'b1;
        repeat (3) tick();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_y_data", bus.y_data, 0);
        chk("rst_y_id", bus.y_id, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // T1: plain two-pair job on requester 0.
        submit(0, 2, 2, 3, 0, 4, 5, 0, 0, 1, expv);
        chk("pin_t1", expv, 23);
        wait_done("t1");

        // T2: product and accumulator saturation, then ReLU of a negative sum.
        submit(1, 2, 300, 300, 0, 300, 300, 0, 0, 1, expv);
        chk("pin_t2a", expv, 32767);
        wait_done("t2a");
        submit(1, 1, -300, 0, 0, 300, 0, 0, 0, 1, expv);
        chk("pin_t2b", expv, 0);
        wait_done("t2b");

        // T3: both requesters saturated with 3-pair jobs; grants alternate from 0.
        hs_q.delete();
        submit(0, 3, 1, 2, 3, 1, 1, 1, 0, 1, expv);
        chk("pin_t3a", expv, 6);
        submit(1, 3, 100, 200, -50, 100, 100, 100, 0, 1, expv);
        chk("pin_t3b", expv, 25000);
        submit(0, 3, 10, -3, 4, 10, 10, -1, 0, 1, expv);
        chk("pin_t3c", expv, 66);
        submit(1, 3, -7, 8, 9, 3, -2, 1, 0, 1, expv);
        chk("pin_t3d", expv, 0);
        wait_done("t3");
        chk("t3_hs_count", hs_q.size(), 4);
        for (int i = 1; i < 4 && i < hs_q.size(); i++)
            chk("t3_turnaround", hs_q[i] - hs_q[i-1], 6);

        // T4: bubbles between pairs do not add anything.
        submit(0, 3, 1, 1, 1, 7, 7, 7, 2, 1, expv);
        chk("pin_t4", expv, 21);
        wait_done("t4");

        // T5: result back-pressure; a pending requester waits for the handshake.
        bus.y_ready = 1'b0;
        submit(0, 1, 3, 0, 0, 3, 0, 0, 0, 1, expv);
        chk("pin_t5a", expv, 9);
        for (int n = 0; n < 50 && !bus.y_valid; n++) tick();
        chk("t5_y_valid_seen", bus.y_valid, 1);
        submit(1, 1, 2, 0, 0, 2, 0, 0, 0, 1, expv);
        repeat (5) begin
            tick();
            chk("t5_hold_valid", bus.y_valid, 1);
            chk("t5_hold_ready", bus.req_ready, 0);
        end
        bus.y_ready = 1'b1;
        tick();
        chk("t5_bubble_ready", bus.req_ready, 0);
        chk("t5_bubble_busy", busy, 0);
        tick();
        chk("t5_grant1", bus.req_ready, 2);
        chk("t5_grant1_busy", busy, 1);
        wait_done("t5");

        // T6: reset in the middle of a job discards it and restarts arbitration.
        submit(0, 3, 1, 2, 3, 1, 1, 1, 1, 0, expv);
        for (int n = 0; n < 20 && !bus.req_ready[0]; n++) tick();
        chk("t6_granted0", bus.req_ready, 1);
        tick();
        reset = 1'b1;
        pq[0].delete();
        tick();
        chk("t6_rst_ready", bus.req_ready, 0);
        chk("t6_rst_y_valid", bus.y_valid, 0);
        chk("t6_rst_y_data", bus.y_data, 0);
        chk("t6_rst_y_id", bus.y_id, 0);
        chk("t6_rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        submit(1, 1, 4, 0, 0, -2, 0, 0, 0, 1, expv);
        chk("pin_t6a", expv, 0);
        wait_done("t6a");
        submit(0, 1, 5, 0, 0, 6, 0, 0, 0, 1, expv);
        chk("pin_t6b", expv, 30);
        wait_done("t6b");

        // After another reset, simultaneous requests go to requester 0 first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        submit(0, 1, -5, 0, 0, -6, 0, 0, 0, 1, expv);
        chk("pin_t6c", expv, 30);
        submit(1, 1, -32768, 0, 0, -32768, 0, 0, 0, 1, expv);
        chk("pin_t6d", expv, 32767);
        wait_done("t6c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
